pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register that replaces fixed-width, enable-only inter-stage latches such as the decode/execute PC+4 register. It carries a WIDTH-bit payload with a valid/ready handshake, a synchronous flush for branch/exception squash, and an optional skid slot. With the skid slot enabled, in_ready is registered and the stage sustains one beat per cycle. It sits between any two pipeline stages (IF/DE, DE/EX, EX/MEM, MEM/WB) and has one instance per boundary.

---
 rtl/pipe_skid_reg_pkg.sv | 5 +
 rtl/pipe_skid_reg_if.sv | 8 +
 rtl/pipe_skid_reg_slot.sv | 18 +
 rtl/pipe_skid_reg.sv | 57 +++++
 tb/tb_pipe_skid_reg.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_pkg: shared state encoding and payload constants for pipeline-stage registers
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY = 2'd0, PS_ONE = 2'd1, PS_TWO = 2'd2} pipe_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: handshake, payload, flush and occupancy bundle of one pipeline stage
interface pipe_skid_reg_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0] count;
  modport master (output in_valid, in_data, out_ready, flush, input in_ready, out_valid, out_data, count);
  modport slave (input in_valid, in_data, out_ready, flush, output in_ready, out_valid, out_data, count);
endinterface

// File: rtl/pipe_skid_reg_slot.sv
// pipe_slot: payload register with load and clear-to-bubble controls
module pipe_slot #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over load so a squash never lets a beat through
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= BUBBLE_VALUE;
    else if (clr) q <= BUBBLE_VALUE;
    else if (ld) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with flush and optional skid slot
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter bit REG_READY = 1'b1
) (
  input logic clk,
  input logic rst,
  pipe_skid_reg_if.slave p
);
  pipe_state_e state, nxt;
  logic rdy_q, ov, rdy, acc, pop, m_ld, m_clr;
  logic [WIDTH-1:0] m_q, s_q, m_d;
  assign ov = state != PS_EMPTY;
  assign rdy = REG_READY ? rdy_q : (!ov | p.out_ready);
  assign acc = p.in_valid & rdy;
  assign pop = ov & p.out_ready;
  assign p.out_valid = ov;
  assign p.out_data = m_q;
  assign p.count = state;
  assign p.in_ready = rdy;
  // next state; flush overrides every handshake event
  always_comb
    nxt = p.flush ? PS_EMPTY :
          state == PS_EMPTY ? (acc ? PS_ONE : PS_EMPTY) :
          state == PS_ONE ? (acc && !pop ? PS_TWO : !acc && pop ? PS_EMPTY : PS_ONE) :
          (pop ? PS_ONE : PS_TWO);
  // state and registered ready, which drops exactly when the stage becomes full
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= PS_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= nxt;
      rdy_q <= nxt != PS_TWO;
    end
  assign m_clr = p.flush | (state == PS_ONE & !acc & pop);
  assign m_ld = (state == PS_EMPTY & acc) | (state == PS_ONE & acc & pop) | (state == PS_TWO & pop);
  assign m_d = state == PS_TWO ? s_q : p.in_data;
  pipe_slot #(.WIDTH(WIDTH), .BUBBLE_VALUE(BUBBLE_VALUE)) u_main (
    .clk(clk), .rst(rst), .ld(m_ld), .clr(m_clr), .d(m_d), .q(m_q)
  );
  generate
    if (REG_READY) begin : g_skid
      logic s_ld, s_clr;
      assign s_ld = state == PS_ONE & acc & !pop;
      assign s_clr = p.flush | (state == PS_TWO & pop);
      pipe_slot #(.WIDTH(WIDTH), .BUBBLE_VALUE(BUBBLE_VALUE)) u_skid (
        .clk(clk), .rst(rst), .ld(s_ld), .clr(s_clr), .d(p.in_data), .q(s_q)
      );
    end else begin : g_noskid
      assign s_q = BUBBLE_VALUE;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: four stage configurations checked against a FIFO-queue model
module tb_pipe_skid_reg;
  import pipe_pkg::*;
  logic clk = 1'b0, rst = 1'b0, fl;
  always #5 clk = ~clk;
  logic iv[4], ordy[4], ir[4], ov[4];
  logic [63:0] id[4], od[4];
  logic [1:0] cnt[4];
  localparam bit RR [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [63:0] MASK [4] = '{64'hffff_ffff, 64'hffff_ffff, 64'h1, {64{1'b1}}};
  localparam logic [63:0] BUB [4] = '{64'h13, 64'h0, 64'h0, 64'h0};
  logic [63:0] q[4][$];
  int errors = 0, checks = 0;

  pipe_skid_reg_if #(.WIDTH(32)) b0();
  pipe_skid_reg_if #(.WIDTH(32)) b1();
  pipe_skid_reg_if #(.WIDTH(1))  b2();
  pipe_skid_reg_if #(.WIDTH(64)) b3();
  pipe_skid_reg #(.WIDTH(32), .BUBBLE_VALUE(NOP), .REG_READY(1'b1)) u0 (.clk(clk), .rst(rst), .p(b0.slave));
  pipe_skid_reg #(.WIDTH(32), .BUBBLE_VALUE(32'h0), .REG_READY(1'b0)) u1 (.clk(clk), .rst(rst), .p(b1.slave));
  pipe_skid_reg #(.WIDTH(1), .BUBBLE_VALUE(1'b0), .REG_READY(1'b1)) u2 (.clk(clk), .rst(rst), .p(b2.slave));
  pipe_skid_reg #(.WIDTH(64), .BUBBLE_VALUE(64'h0), .REG_READY(1'b1)) u3 (.clk(clk), .rst(rst), .p(b3.slave));

  assign b0.in_valid = iv[0]; assign b0.in_data = id[0][31:0]; assign b0.out_ready = ordy[0]; assign b0.flush = fl;
  assign b1.in_valid = iv[1]; assign b1.in_data = id[1][31:0]; assign b1.out_ready = ordy[1]; assign b1.flush = fl;
  assign b2.in_valid = iv[2]; assign b2.in_data = id[2][0:0];  assign b2.out_ready = ordy[2]; assign b2.flush = fl;
  assign b3.in_valid = iv[3]; assign b3.in_data = id[3];       assign b3.out_ready = ordy[3]; assign b3.flush = fl;
  assign ir[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign od[0] = 64'(b0.out_data); assign cnt[0] = b0.count;
  assign ir[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign od[1] = 64'(b1.out_data); assign cnt[1] = b1.count;
  assign ir[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign od[2] = 64'(b2.out_data); assign cnt[2] = b2.count;
  assign ir[3] = b3.in_ready; assign ov[3] = b3.out_valid; assign od[3] = 64'(b3.out_data); assign cnt[3] = b3.count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic bit erdy(input int k);
    return RR[k] ? (q[k].size() != 2) : (q[k].size() == 0 || ordy[k]);
  endfunction

  task automatic check_out();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(q[k].size() > 0));
      chk($sformatf("out_data%0d", k), od[k], q[k].size() > 0 ? q[k][0] : BUB[k]);
      chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(q[k].size()));
    end
  endtask

  task automatic tick();
    bit a[4], po[4];
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(erdy(k)));
      a[k] = iv[k] && erdy(k);
      po[k] = q[k].size() > 0 && ordy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (fl) q[k].delete();
      else begin
        if (po[k]) void'(q[k].pop_front());
        if (a[k]) q[k].push_back(id[k] & MASK[k]);
      end
    #1;
    check_out();
  endtask

  task automatic set_all(input bit v, input logic [63:0] d, input bit r);
    for (int k = 0; k < 4; k++) begin
      iv[k] = v;
      id[k] = d;
      ordy[k] = r;
    end
  endtask

  initial begin
    fl = 1'b0;
    set_all(1'b0, 64'h0, 1'b1);
    #12;
    check_out();
    for (int k = 0; k < 4; k++) chk($sformatf("rst_ready%0d", k), 64'(ir[k]), 64'h1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      set_all(1'b1, 64'(i), 1'b1);
      tick();
    end
    set_all(1'b0, 64'h0, 1'b1);
    tick();
    tick();
    set_all(1'b1, 64'hA, 1'b1);
    tick();
    set_all(1'b1, 64'hB, 1'b0);
    tick();
    chk("stall_count", 64'(cnt[0]), 64'h2);
    chk("stall_ready", 64'(ir[0]), 64'h0);
    set_all(1'b1, 64'hC, 1'b0);
    tick();
    tick();
    set_all(1'b1, 64'hC, 1'b1);
    tick();
    set_all(1'b0, 64'h0, 1'b1);
    repeat (4) tick();
    set_all(1'b1, 64'h51, 1'b0);
    tick();
    set_all(1'b1, 64'h52, 1'b0);
    tick();
    fl = 1'b1;
    set_all(1'b1, 64'hDEAD, 1'b0);
    tick();
    fl = 1'b0;
    chk("flush_count", 64'(cnt[0]), 64'h0);
    chk("flush_data", od[0], 64'h13);
    chk("flush_valid", 64'(ov[0]), 64'h0);
    set_all(1'b0, 64'h0, 1'b1);
    repeat (3) tick();
    set_all(1'b1, 64'h11, 1'b1);
    tick();
    set_all(1'b1, 64'h22, 1'b1);
    tick();
    chk("simul_count", 64'(cnt[0]), 64'h1);
    chk("simul_data", od[0], 64'h22);
    set_all(1'b1, 64'h33, 1'b0);
    tick();
    set_all(1'b0, 64'h0, 1'b0);
    #1 chk("rr0_stall_ready", 64'(ir[1]), 64'h0);
    ordy[1] = 1'b1;
    #1 chk("rr0_release_ready", 64'(ir[1]), 64'h1);
    tick();
    set_all(1'b1, 64'h44, 1'b0);
    tick();
    tick();
    set_all(1'b0, 64'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) q[k].delete();
    check_out();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 4; k++) begin
        iv[k] = ($urandom % 4) != 0;
        id[k] = {$urandom, $urandom};
        ordy[k] = n < 400 ? ($urandom % 3) != 0 : ($urandom % 3) == 0;
      end
      fl = n > 200 && ($urandom % 40) == 0;
      tick();
    end
    fl = 1'b0;
    set_all(1'b0, 64'h0, 1'b1);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
